// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants and state type for the 8-channel mux scan sequencer.
package mux_scan_ctrl_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Bit position in the result byte that a given channel's sample occupies.
    function automatic logic [SEL_W-1:0] slotIndex(input logic [SEL_W-1:0] sel,
                                                   input bit lsbFirst);
        return lsbFirst ? sel : (SEL_W'(NUM_CH - 1) - sel);
    endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Steps the 8:1 mux select through channels 0..7, samples y per channel and
// publishes the assembled byte with a start/busy/done handshake.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 0,
    parameter bit          LSB_FIRST     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              y,
    output logic              s0,
    output logic              s1,
    output logic              s2,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] data
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(NUM_CH - 1);

    state_e             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_CH-1:0]  capture_q;
    logic [NUM_CH-1:0]  capture_d;
    logic [NUM_CH-1:0]  data_q;
    logic               busy_q;
    logic               done_q;

    // Capture image with the current channel's sample merged in, so the last
    // channel lands in data on the same edge it is sampled.
    always_comb begin
        capture_d = capture_q;
        capture_d[slotIndex(sel_q, LSB_FIRST)] = y;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            capture_q <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SCAN;
                        sel_q   <= '0;
                        cnt_q   <= SETTLE_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        capture_q <= capture_d;
                        if (sel_q == LAST_CH) begin
                            state_q <= ST_IDLE;
                            sel_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            data_q  <= capture_d;
                        end else begin
                            sel_q <= sel_q + SEL_W'(1);
                            cnt_q <= SETTLE_LOAD;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s0   = sel_q[0];
    assign s1   = sel_q[1];
    assign s2   = sel_q[2];
    assign busy = busy_q;
    assign done = done_q;
    assign data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Four scan controllers with different settle/order settings, each paired with
// a behavioural 8:1 mux, checked every cycle against a channel-schedule model.
module tb_mux_scan_ctrl;

    localparam int NI = 4;
    localparam int SETTLE_T [NI] = '{0, 3, 0, 2};
    localparam bit LSBF_T   [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] start;
    logic [7:0]    muxIn [NI];

    wire  [NI-1:0] y, s0, s1, s2, busy, done;
    wire  [7:0]    data [NI];

    int assertCount = 0;
    int failCount   = 0;
    bit chkEn       = 1'b0;

    bit         mBusy    [NI];
    bit         mDone    [NI];
    int         mElapsed [NI];
    logic [7:0] mCap     [NI];
    logic [7:0] mData    [NI];
    int         busyRun  [NI];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : gInst
            mux_scan_ctrl #(
                .SETTLE_CYCLES(SETTLE_T[g]),
                .LSB_FIRST    (LSBF_T[g])
            ) dut (
                .clk  (clk),
                .rst_n(rst_n),
                .start(start[g]),
                .y    (y[g]),
                .s0   (s0[g]),
                .s1   (s1[g]),
                .s2   (s2[g]),
                .busy (busy[g]),
                .done (done[g]),
                .data (data[g])
            );
            assign y[g] = muxIn[g][{s2[g], s1[g], s0[g]}];
        end
    endgenerate

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NI-1:0] mask);
        start = mask;
        @(negedge clk);
        start = '0;
    endtask

    // Channel currently selected: each channel owns SETTLE+1 consecutive cycles.
    function automatic int mSel(input int i);
        return mBusy[i] ? (mElapsed[i] / (SETTLE_T[i] + 1)) : 0;
    endfunction

    // Model: time since scan start decides channel, sample instant and completion.
    always @(posedge clk) begin
        int ch;
        int per;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                mBusy[i]    = 1'b0;
                mDone[i]    = 1'b0;
                mElapsed[i] = 0;
                mCap[i]     = 8'h00;
                mData[i]    = 8'h00;
            end else begin
                mDone[i] = 1'b0;
                if (mBusy[i]) begin
                    per = SETTLE_T[i] + 1;
                    ch  = mSel(i);
                    if ((mElapsed[i] % per) == per - 1) begin
                        if (LSBF_T[i]) mCap[i][ch]     = muxIn[i][ch];
                        else           mCap[i][7 - ch] = muxIn[i][ch];
                    end
                    mElapsed[i]++;
                    if (mElapsed[i] == 8 * per) begin
                        mBusy[i]    = 1'b0;
                        mDone[i]    = 1'b1;
                        mData[i]    = mCap[i];
                        mElapsed[i] = 0;
                    end
                end else if (start[i]) begin
                    mBusy[i]    = 1'b1;
                    mElapsed[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            for (int i = 0; i < NI; i++) begin
                checkOutput($sformatf("inst%0d sel", i), {5'b0, s2[i], s1[i], s0[i]}, 8'(mSel(i)));
                checkOutput($sformatf("inst%0d busy", i), {7'b0, busy[i]}, {7'b0, mBusy[i]});
                checkOutput($sformatf("inst%0d done", i), {7'b0, done[i]}, {7'b0, mDone[i]});
                checkOutput($sformatf("inst%0d data", i), data[i], mData[i]);
                if (busy[i] === 1'b1) begin
                    busyRun[i]++;
                end else begin
                    if (mDone[i])
                        checkOutput($sformatf("inst%0d busy length", i), 8'(busyRun[i]),
                                    8'(8 * (SETTLE_T[i] + 1)));
                    busyRun[i] = 0;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = '0;
        for (int i = 0; i < NI; i++) begin
            muxIn[i]   = 8'hB2;
            busyRun[i] = 0;
        end
        muxIn[3] = 8'hBA;

        repeat (2) @(negedge clk);
        chkEn = 1'b1;
        checkOutput("reset data", data[0], 8'h00);
        checkOutput("reset busy", {7'b0, busy[0]}, 8'h00);
        checkOutput("reset sel", {5'b0, s2[0], s1[0], s0[0]}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single scans on all settings");
        applyStimulus(4'hF);
        repeat (9) @(negedge clk);
        muxIn[3][3] = 1'b0;
        @(negedge clk);
        muxIn[3][3] = 1'b1;
        repeat (29) @(negedge clk);
        checkOutput("settle0 data", data[0], 8'hB2);
        checkOutput("settle3 data", data[1], 8'hB2);
        checkOutput("msb-first data", data[2], 8'h4D);
        checkOutput("settle glitch data", data[3], 8'hBA);
        checkOutput("all idle", {4'b0, busy}, 8'h00);

        $display("[TB] back-to-back scans");
        start[0] = 1'b1;
        repeat (9) @(negedge clk);
        checkOutput("b2b done1", {7'b0, done[0]}, 8'h01);
        checkOutput("b2b data1", data[0], 8'hB2);
        muxIn[0] = 8'h0F;
        @(negedge clk);
        checkOutput("b2b scan2 busy", {7'b0, busy[0]}, 8'h01);
        repeat (2) @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("b2b done2", {7'b0, done[0]}, 8'h01);
        checkOutput("b2b data2", data[0], 8'h0F);
        repeat (10) @(negedge clk);
        checkOutput("no extra scan", {7'b0, busy[0]}, 8'h00);
        checkOutput("data held", data[0], 8'h0F);

        $display("[TB] reset mid-scan");
        muxIn[0] = 8'hB2;
        applyStimulus(4'h1);
        repeat (8) @(negedge clk);
        checkOutput("pre-reset data", data[0], 8'hB2);
        @(negedge clk);
        applyStimulus(4'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort sel", {5'b0, s2[0], s1[0], s0[0]}, 8'h00);
        checkOutput("abort busy", {7'b0, busy[0]}, 8'h00);
        checkOutput("abort done", {7'b0, done[0]}, 8'h00);
        checkOutput("abort data", data[0], 8'h00);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("no done after abort", {7'b0, done[0]}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
